// File: rtl/demorgan_sweep_checker.sv
// Exhaustive two-input gate checker: drives {a,b} = 00,01,10,11, samples c_in after settling.
// Define DEMORGAN_SWEEP_LOOP_EN for continuous sweeping with a stop input.
module demorgan_sweep_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  EXPECT_TT   = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef DEMORGAN_SWEEP_LOOP_EN
    input  logic       stop,
`endif
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic [1:0] ab_q, ab_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       mismatch_s;
`ifdef DEMORGAN_SWEEP_LOOP_EN
    logic       stop_seen_q, stop_seen_d;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign mismatch_s = (c_in != EXPECT_TT[idx_q]);

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fail_d  = fail_q;
`ifdef DEMORGAN_SWEEP_LOOP_EN
        stop_seen_d = stop_seen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    hold_d  = 8'd0;
                    idx_d   = 2'd0;
                    err_d   = 4'd0;
                    fail_d  = 4'd0;
`ifdef DEMORGAN_SWEEP_LOOP_EN
                    stop_seen_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
`ifdef DEMORGAN_SWEEP_LOOP_EN
                if (stop) begin
                    stop_seen_d = 1'b1;
                end else begin
                    stop_seen_d = stop_seen_q;
                end
`endif
                // Only the final hold cycle is trusted; earlier cycles let the gate settle.
                if (hold_q == HOLD_LAST) begin
                    if (mismatch_s) begin
                        fail_d = fail_q | (4'b0001 << idx_q);
                        err_d  = sat_inc(err_q);
                    end else begin
                        fail_d = fail_q;
                        err_d  = err_q;
                    end
                    hold_d = 8'd0;
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_DONE: begin
`ifdef DEMORGAN_SWEEP_LOOP_EN
                if (stop || stop_seen_q) begin
                    state_d     = S_IDLE;
                    stop_seen_d = 1'b0;
                end else begin
                    state_d = S_DRIVE;
                    hold_d  = 8'd0;
                    idx_d   = 2'd0;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_DRIVE);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == 4'd0);
        ab_d   = (state_d == S_DRIVE) ? idx_d : 2'b00;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= 8'd0;
            idx_q   <= 2'd0;
            err_q   <= 4'd0;
            fail_q  <= 4'd0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef DEMORGAN_SWEEP_LOOP_EN
            stop_seen_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef DEMORGAN_SWEEP_LOOP_EN
            stop_seen_q <= stop_seen_d;
`endif
        end
    end

    assign a_out    = ab_q[1];
    assign b_out    = ab_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Directed bench for demorgan_sweep_checker: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances.
module tb_demorgan_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n, start, start1, stop;
    logic       c0, c1;
    logic       a0, b0, busy0, done0, pass0;
    logic [3:0] err0, fail0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] err1, fail1;
    logic [1:0] mode;
    logic [7:0] age;
    logic [1:0] last_ab;
    logic       last_busy;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    demorgan_sweep_checker #(.HOLD_CYCLES(4), .EXPECT_TT(4'b0111)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef DEMORGAN_SWEEP_LOOP_EN
        .stop(stop),
`endif
        .c_in(c0), .a_out(a0), .b_out(b0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err0), .fail_vec(fail0)
    );

    demorgan_sweep_checker #(.HOLD_CYCLES(1), .EXPECT_TT(4'b0111)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef DEMORGAN_SWEEP_LOOP_EN
        .stop(1'b1),
`endif
        .c_in(c1), .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
    );

    // Gate models: 0 NAND, 1 stuck-at-1, 2 NAND corrupted for first 3 cycles of a vector, 3 stuck-at-0.
    always_comb begin
        case (mode)
            2'd0: c0 = ~(a0 & b0);
            2'd1: c0 = 1'b1;
            2'd2: c0 = (age < 8'd3) ? (a0 & b0) : ~(a0 & b0);
            default: c0 = 1'b0;
        endcase
        c1 = ~(a1 & b1);
    end

    // Cycles since the applied vector last changed (or the sweep began).
    always @(negedge clk) begin
        if (({a0, b0} != last_ab) || (busy0 && !last_busy)) age <= 8'd0;
        else if (age != 8'hFF) age <= age + 8'd1;
        last_ab   <= {a0, b0};
        last_busy <= busy0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input logic [1:0] m, input logic ep, input logic [3:0] ee, input logic [3:0] ef);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("busy_c%0d", k), {7'd0, busy0}, 8'd1);
            chk($sformatf("ab_c%0d", k), {6'd0, a0, b0}, 8'(k / 4));
            chk($sformatf("done_c%0d", k), {7'd0, done0}, 8'd0);
            tick();
        end
        chk("busy_in_done", {7'd0, busy0}, 8'd0);
        chk("done_pulse", {7'd0, done0}, 8'd1);
        chk("pass", {7'd0, pass0}, {7'd0, ep});
        chk("err_cnt", {4'd0, err0}, {4'd0, ee});
        chk("fail_vec", {4'd0, fail0}, {4'd0, ef});
        tick();
        chk("done_end", {7'd0, done0}, 8'd0);
        chk("busy_idle", {7'd0, busy0}, 8'd0);
        chk("ab_idle", {6'd0, a0, b0}, 8'd0);
        chk("err_hold", {4'd0, err0}, {4'd0, ee});
        chk("fail_hold", {4'd0, fail0}, {4'd0, ef});
    endtask

    initial begin
        logic [7:0] busy_exp [12];
        logic [7:0] done_exp [12];
        logic [7:0] ab_exp   [12];
        busy_exp = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
        done_exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
        ab_exp   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0};
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; stop = 1'b1; mode = 2'd0;
        age = 8'd0; last_ab = 2'b00; last_busy = 1'b0;
        tick();
        tick();
        chk("rst_ab", {6'd0, a0, b0}, 8'd0);
        chk("rst_busy", {7'd0, busy0}, 8'd0);
        chk("rst_done", {7'd0, done0}, 8'd0);
        chk("rst_pass", {7'd0, pass0}, 8'd0);
        chk("rst_err", {4'd0, err0}, 8'd0);
        chk("rst_fail", {4'd0, fail0}, 8'd0);
        start = 1'b1;
        tick();
        chk("rst_over_start", {7'd0, busy0}, 8'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        sweep(2'd0, 1'b1, 4'd0, 4'b0000);
        sweep(2'd1, 1'b0, 4'd1, 4'b1000);
        sweep(2'd2, 1'b1, 4'd0, 4'b0000);

        // Abort mid-sweep: stuck-at-0 has already failed vector 00 by busy cycle 7.
        mode  = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("mid_busy", {7'd0, busy0}, 8'd1);
        chk("mid_err", {4'd0, err0}, 8'd1);
        chk("mid_fail", {4'd0, fail0}, 8'b0001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", {7'd0, busy0}, 8'd0);
        chk("abort_ab", {6'd0, a0, b0}, 8'd0);
        chk("abort_err", {4'd0, err0}, 8'd0);
        chk("abort_fail", {4'd0, fail0}, 8'd0);
        chk("abort_done", {7'd0, done0}, 8'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("no_done_after_abort", {7'd0, done0}, 8'd0);
        end
        sweep(2'd0, 1'b1, 4'd0, 4'b0000);

        // HOLD_CYCLES=1 with start held for 10 edges: two sweeps, DONE and IDLE between.
        start1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 9) start1 = 1'b0;
            chk($sformatf("h1_busy_%0d", k), {7'd0, busy1}, busy_exp[k]);
            chk($sformatf("h1_done_%0d", k), {7'd0, done1}, done_exp[k]);
            chk($sformatf("h1_ab_%0d", k), {6'd0, a1, b1}, ab_exp[k]);
        end
        chk("h1_pass", {7'd0, pass1}, 8'd0);
        chk("h1_err", {4'd0, err1}, 8'd0);

`ifdef DEMORGAN_SWEEP_LOOP_EN
        mode  = 2'd3;
        stop  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 1; s <= 6; s++) begin
            for (int k = 0; k < 16; k++) begin
                if (s == 6 && k == 5) stop = 1'b1;
                chk($sformatf("loop_busy_s%0d", s), {7'd0, busy0}, 8'd1);
                tick();
            end
            chk($sformatf("loop_done_s%0d", s), {7'd0, done0}, 8'd1);
            chk($sformatf("loop_err_s%0d", s), {4'd0, err0}, (3 * s > 15) ? 8'd15 : 8'(3 * s));
            chk($sformatf("loop_fail_s%0d", s), {4'd0, fail0}, 8'b0111);
            chk($sformatf("loop_pass_s%0d", s), {7'd0, pass0}, 8'd0);
            tick();
        end
        chk("loop_idle_busy", {7'd0, busy0}, 8'd0);
        chk("loop_idle_done", {7'd0, done0}, 8'd0);
        tick();
        chk("loop_idle_stay", {7'd0, busy0}, 8'd0);
        chk("loop_err_final", {4'd0, err0}, 8'd15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
